// File: rtl/doc_uart_sequencer_pkg.sv
// Shared definitions for the document-to-UART sequencer: document geometry,
// special characters and the sequencer state encoding.
package doc_uart_sequencer_pkg;

  localparam int DOC_ROWS   = 16;
  localparam int DOC_COLS   = 32;
  localparam int DOC_ADDR_W = 9;

  localparam logic [7:0] EOL_CHAR   = 8'h0A;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FREE = 3'd1,
    FETCH     = 3'd2,
    LATCH     = 3'd3,
    SEND      = 3'd4,
    EOL       = 3'd5,
    CLEAR     = 3'd6,
    FINISH    = 3'd7
  } state_t;

endpackage

// File: rtl/doc_uart_sequencer.sv
// Streams the whole character document to the UART serializer row by row,
// appending a newline per row, then optionally clears the document.
module doc_uart_sequencer #(
  parameter int                ADDR_W      = doc_uart_sequencer_pkg::DOC_ADDR_W,
  parameter int                DATA_W      = 8,
  parameter int                COLS        = doc_uart_sequencer_pkg::DOC_COLS,
  parameter int                ROWS        = doc_uart_sequencer_pkg::DOC_ROWS,
  parameter logic [DATA_W-1:0] EOL_CHAR    = doc_uart_sequencer_pkg::EOL_CHAR,
  parameter logic [DATA_W-1:0] BLANK_CHAR  = doc_uart_sequencer_pkg::BLANK_CHAR,
  parameter bit                CLEAR_AFTER = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_req,
  input  logic              editor_busy,
  output logic              read_enable,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              clear_data,
  output logic              active,
  output logic              done
);
  import doc_uart_sequencer_pkg::*;

  localparam int                COL_W     = $clog2(COLS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);

  function automatic logic [DATA_W-1:0] map_blank(input logic [DATA_W-1:0] d);
    return (d == '0) ? BLANK_CHAR : d;
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_read_addr;
  logic [DATA_W-1:0] r_tx_data;
  logic              w_tx_valid;
  logic              w_accept;
  logic              w_last_col;
  logic              w_last_addr;

  assign w_accept    = w_tx_valid && tx_ready;
  assign w_last_col  = (r_read_addr[COL_W-1:0] == LAST_COL);
  assign w_last_addr = (r_read_addr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Address and outgoing byte; EOL is preloaded on the accept of the last column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_addr <= '0;
      r_tx_data   <= '0;
    end else begin
      case (r_state)
        IDLE:  if (send_req) r_read_addr <= '0;
        LATCH: r_tx_data <= map_blank(read_data);
        SEND:
          if (w_accept) begin
            if (w_last_col) r_tx_data   <= EOL_CHAR;
            else            r_read_addr <= r_read_addr + 1'b1;
          end
        EOL:   if (w_accept && !w_last_addr) r_read_addr <= r_read_addr + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    read_enable = 1'b0;
    w_tx_valid  = 1'b0;
    clear_data  = 1'b0;
    active      = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        active = 1'b0;
        if (send_req) w_next = WAIT_FREE;
      end
      WAIT_FREE: if (!editor_busy) w_next = FETCH;
      FETCH: begin
        read_enable = 1'b1;
        w_next      = LATCH;
      end
      LATCH: begin
        read_enable = 1'b1;
        w_next      = SEND;
      end
      SEND: begin
        read_enable = 1'b1;
        w_tx_valid  = 1'b1;
        if (w_accept) w_next = w_last_col ? EOL : FETCH;
      end
      EOL: begin
        read_enable = 1'b1;
        w_tx_valid  = 1'b1;
        if (w_accept) begin
          if (!w_last_addr)     w_next = FETCH;
          else if (CLEAR_AFTER) w_next = CLEAR;
          else                  w_next = FINISH;
        end
      end
      CLEAR: begin
        clear_data = 1'b1;
        w_next     = FINISH;
      end
      FINISH: begin
        active = 1'b0;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign read_addr = r_read_addr;
  assign tx_data   = r_tx_data;
  assign tx_valid  = w_tx_valid;

endmodule

// File: doc/doc_uart_sequencer.md
Name: doc_uart_sequencer

Overview:
Sequencer that streams the 16x32 character document out over UART when the user presses send. It takes ownership of the document read port (the text editor's read_enable/read_out_addr/clear_data path) and walks all 512 cells row by row. Each character is handed to the sibling uart_tx serializer over a valid/ready handshake, with a newline after every row. Once the last byte is accepted it optionally pulses clear_data to wipe the document.

Parameters:
ADDR_W, 9, document address width; address = {row[3:0], col[4:0]}
DATA_W, 8, character width
COLS, 32, cells per row; a newline is emitted after col COLS-1
ROWS, 16, rows in the document
EOL_CHAR, 8'h0A, byte sent after each row
BLANK_CHAR, 8'h20, substitute byte for empty cells (code 8'h00)
CLEAR_AFTER, 1, 1 = pulse clear_data after a complete transfer

Ports:
clk  in  1  system clock (clk_25MHz domain)
rst  in  1  reset, asynchronous, active-high
send_req  in  1  one-cycle start pulse (debounced, one-pulsed upstream)
editor_busy  in  1  recognizer/editor write in progress; start is deferred while high
read_enable  out  1  owns the document read port while high
read_addr  out  ADDR_W  document cell address
read_data  in  DATA_W  document spo; valid at most one cycle after read_addr changes
tx_data  out  DATA_W  byte to serializer
tx_valid  out  1  tx_data valid
tx_ready  in  1  serializer accepts when tx_valid && tx_ready at a clk edge
clear_data  out  1  one-cycle pulse: clear the document
active  out  1  transfer in progress
done  out  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset (async, any state): state=IDLE. read_enable, read_addr, tx_data, tx_valid, clear_data, active and done all drive 0. tx_valid drops in the same instant reset asserts, with no cycle delay.
- FSM states: IDLE, WAIT_FREE, FETCH, LATCH, SEND, EOL, CLEAR, FINISH.
- IDLE: send_req=1 -> WAIT_FREE, and read_addr is cleared to 0. send_req while not in IDLE is ignored.
- WAIT_FREE: active=1. Stay while editor_busy=1. editor_busy=0 -> FETCH.
- FETCH: read_enable=1 from here through EOL. Present read_addr for one cycle, then -> LATCH.
- LATCH: capture read_data, mapping 8'h00 to BLANK_CHAR; all other codes pass unchanged. Load the result into tx_data, set tx_valid=1, -> SEND.
- Read latency: this gives 2 cycles from address to tx_valid. That is correct for both the combinational and the 1-cycle-registered document port.
- SEND: hold tx_valid=1 with tx_data stable until tx_valid && tx_ready. On that edge:
  - if col==COLS-1 -> EOL with tx_data=EOL_CHAR, tx_valid kept at 1;
  - else read_addr+1 -> FETCH, tx_valid=0.
- EOL: hold EOL_CHAR until accepted. On accept:
  - if read_addr==ROWS*COLS-1 -> CLEAR (or FINISH when CLEAR_AFTER=0);
  - else read_addr+1 -> FETCH.
- Address never wraps; 511 is terminal.
- CLEAR: read_enable=0 and clear_data=1 for exactly one cycle, then -> FINISH.
- FINISH: done=1 for one cycle, active=0, -> IDLE.
- editor_busy rising mid-transfer is ignored, because the port is already owned.
- tx_ready high with tx_valid low has no effect.
- send_req on the same edge that FINISH returns to IDLE is dropped.
- Total output per transfer: ROWS*(COLS+1) = 528 bytes.
- Minimum per-byte overhead: 2 idle cycles between a character accept and the next tx_valid. EOL follows its character with no gap.

Decomposition:
- Shared package holds:
  - DOC_ROWS=16, DOC_COLS=32, DOC_ADDR_W=9;
  - EOL_CHAR and BLANK_CHAR;
  - the FSM state enum, 3 bits: IDLE=0, WAIT_FREE=1, FETCH=2, LATCH=3, SEND=4, EOL=5, CLEAR=6, FINISH=7.
- No sub-module. uart_tx is a sibling in top, connected via tx_data/tx_valid/tx_ready.

Test Plan:
- Plain transfer: doc cell k = 8'h41+(k%26), tx_ready tied 1, send_req pulse -> exactly 528 bytes, in this order:
  - first three bytes: 41,42,43;
  - byte 33 is 0A; byte 528 is 0A;
  - then one clear_data pulse, followed one cycle later by one done pulse.
- Blank map and backpressure: doc all 8'h00, tx_ready high 1 cycle in every 10 -> every non-EOL byte is 20, and tx_data is stable while tx_valid=1 && tx_ready=0.
- Deferred start: editor_busy=1 for 50 cycles when send_req pulses -> read_enable stays 0 and active=1 throughout; the first FETCH occurs 1 cycle after editor_busy falls.
- Reset mid-operation: async rst asserted after 100 bytes -> tx_valid, read_enable and active go 0 immediately. No clear_data. After release, a new send_req restarts at read_addr 0.
- Ignored requests: send_req pulses at bytes 10 and 400 -> still exactly 528 bytes and one done.
- CLEAR_AFTER=0: full transfer -> clear_data never asserts; done pulses once.
